// File: rtl/seq_bit_serializer_if.sv
// Parallel-word load handshake between the word source and seq_bit_serializer.
// A word transfers on a rising edge where load_valid && load_ready.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the "101" detector: one bit per clock on x, gapless across words.
// Define SER_SKID_EN to add a one-word holding register that accepts the next word mid-shift.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bit_serializer_if.slave  ld,
    output logic                 x,
    output logic                 x_valid,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic             last;
    logic             accept;
    logic             start;
    logic             advance;
    logic [WIDTH-1:0] start_word;

    // Bit k of a word in transmit order; shifting keeps the index width-agnostic.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
        logic [WIDTH-1:0] t;
        if (MSB_FIRST) begin
            t = w << k;
            return t[WIDTH-1];
        end
        t = w >> k;
        return t[0];
    endfunction

    assign last    = (state == SHIFT) && (cnt == CNT_LAST);
    assign cnt_inc = cnt + CW'(1);
    assign accept  = ld.load_valid && ld.load_ready;

`ifdef SER_SKID_EN
    logic             hold_full;
    logic [WIDTH-1:0] hold_word;
    logic             hold_load;
    logic             hold_take;

    assign ld.load_ready = rst && !hold_full;
    assign hold_load     = accept && (state == SHIFT) && !last;
    assign hold_take     = last && hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
        end else if (hold_load) begin
            hold_full <= 1'b1;
        end else if (hold_take) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_word <= ld.load_data;
        end
    end
`else
    assign ld.load_ready = rst && ((state == IDLE) || last);
`endif

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        advance    = 1'b0;
        start_word = ld.load_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    advance = 1'b1;
`ifdef SER_SKID_EN
                end else if (hold_full) begin
                    start      = 1'b1;
                    start_word = hold_word;
`endif
                end else if (accept) begin
                    start = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // A new word reloads the counter and presents its first bit on the very next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                sreg    <= start_word;
                cnt     <= '0;
                x       <= pick_bit(start_word, '0);
                x_valid <= 1'b1;
                busy    <= 1'b1;
                done    <= 1'b0;
            end else if (advance) begin
                cnt  <= cnt_inc;
                x    <= pick_bit(sreg, cnt_inc);
                done <= (cnt_inc == CNT_LAST);
            end else begin
                cnt     <= '0;
                x       <= 1'b0;
                x_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a bit-queue model plus directed sequence vectors.
module tb_seq_bit_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         drv_valid = 1'b0;
    logic [W-1:0] drv_data = '0;
    logic         x_m, xv_m, busy_m, done_m;
    logic         x_l, xv_l, busy_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;

    seq_bit_serializer_if #(.WIDTH(W)) if_m ();
    seq_bit_serializer_if #(.WIDTH(W)) if_l ();

    assign if_m.load_valid = drv_valid;
    assign if_m.load_data  = drv_data;
    assign if_l.load_valid = drv_valid;
    assign if_l.load_data  = drv_data;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .ld(if_m),
        .x(x_m), .x_valid(xv_m), .busy(busy_m), .done(done_m)
    );
    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ld(if_l),
        .x(x_l), .x_valid(xv_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: queues of the bits still to appear on x, head = bit on x now.
    bit           qm[$];
    bit           ql[$];
    bit           hfull = 1'b0;
    bit           took  = 1'b0;
`ifdef SER_SKID_EN
    logic [W-1:0] hword;
`endif

    function automatic bit mready();
`ifdef SER_SKID_EN
        return rst && !hfull;
`else
        return rst && (qm.size() <= 1);
`endif
    endfunction

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back(w[W-1-i]);
            ql.push_back(w[i]);
        end
    endfunction

    initial forever begin
        bit acc;
        @(posedge clk or negedge rst);
        if (!rst) begin
            qm.delete();
            ql.delete();
            hfull = 1'b0;
            took  = 1'b0;
        end else begin
            acc  = drv_valid && mready();
            took = acc;
            if (qm.size() != 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
`ifdef SER_SKID_EN
            if (qm.size() == 0 && hfull) begin
                push_word(hword);
                hfull = 1'b0;
            end
            if (acc) begin
                if (qm.size() == 0) push_word(drv_data);
                else begin
                    hfull = 1'b1;
                    hword = drv_data;
                end
            end
`else
            if (acc) push_word(drv_data);
`endif
        end
    end

    initial forever begin
        bit ev, em, el;
        @(negedge clk);
        ev = (qm.size() != 0);
        em = 1'b0;
        el = 1'b0;
        if (ev) begin
            em = qm[0];
            el = ql[0];
        end
        chk("x_msb", x_m, em);
        chk("x_lsb", x_l, el);
        chk("x_valid_msb", xv_m, ev);
        chk("x_valid_lsb", xv_l, ev);
        chk("busy_msb", busy_m, ev);
        chk("busy_lsb", busy_l, ev);
        chk("done_msb", done_m, qm.size() == 1);
        chk("done_lsb", done_l, ql.size() == 1);
        chk("ready_msb", if_m.load_ready, mready());
        chk("ready_lsb", if_l.load_ready, mready());
    end

    function automatic int hits(input logic [7:0] s);
        int h = 0;
        for (int i = 0; i <= 5; i++) if (s[7-i -: 3] == 3'b101) h++;
        return h;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((qm.size() != 0 || hfull) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 100, 1);
    endtask

    task automatic run_word(input logic [7:0] w, output logic [7:0] sm, output logic [7:0] sl);
        wait_idle();
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = w;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drv_valid = 1'b0;
            sm[7-k] = x_m;
            sl[7-k] = x_l;
        end
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] seq_m;
        logic [7:0] seq_l;
        int         hits_m;
        int         hits_l;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [7:0]  sm, sl;
        logic [15:0] s16m, s16l;

        vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 2, 2};
        vecs[1] = '{8'h01, 8'h01, 8'h80, 0, 0};
        vecs[2] = '{8'h05, 8'h05, 8'hA0, 1, 1};
        vecs[3] = '{8'hC3, 8'hC3, 8'hC3, 0, 0};
        vecs[4] = '{8'h3C, 8'h3C, 8'h3C, 0, 0};
        vecs[5] = '{8'h0F, 8'h0F, 8'hF0, 0, 0};

        #1 rst = 1'b0;
        #2;
        chk("rst_x", x_m, 0);
        chk("rst_x_valid", xv_m, 0);
        chk("rst_ready", if_m.load_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].word, sm, sl);
            chk($sformatf("seq_msb_%0d", i), sm, vecs[i].seq_m);
            chk($sformatf("seq_lsb_%0d", i), sl, vecs[i].seq_l);
            chk($sformatf("hits_msb_%0d", i), hits(sm), vecs[i].hits_m);
            chk($sformatf("hits_lsb_%0d", i), hits(sl), vecs[i].hits_l);
        end

        // Back-to-back 05 then 80 with load_valid held high.
        wait_idle();
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'h05;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) drv_data = 8'h80;
            if (k == 8) drv_valid = 1'b0;
            if (k >= 1 && k <= 6) chk("b2b_stall_ready", if_m.load_ready, 0);
            chk("b2b_gapless", xv_m, 1);
            s16m[15-k] = x_m;
            s16l[15-k] = x_l;
        end
        chk("b2b_seq_msb", s16m, 16'h0580);
        chk("b2b_seq_lsb", s16l, 16'hA001);

`ifndef SER_SKID_EN
        // Pulse FF at bit 3: must be ignored.
        wait_idle();
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'hA5;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drv_valid = 1'b0;
            if (k == 3) begin
                drv_valid = 1'b1;
                drv_data  = 8'hFF;
            end
            if (k == 4) drv_valid = 1'b0;
            sm[7-k] = x_m;
            sl[7-k] = x_l;
        end
        chk("ignore_seq_msb", sm, 8'hA5);
        chk("ignore_seq_lsb", sl, 8'hA5);
        @(negedge clk);
        chk("ignore_no_extra", xv_m, 0);
`endif

        // Reset at bit 4 of F0, then clean 0F.
        wait_idle();
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'hF0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drv_valid = 1'b0;
            sm[7-k] = x_m;
            sl[7-k] = x_l;
        end
        chk("abort_head_msb", sm[7:4], 4'hF);
        chk("abort_head_lsb", sl[7:4], 4'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_x", x_l, 0);
        chk("abort_x_valid", xv_m, 0);
        chk("abort_busy", busy_m, 0);
        chk("abort_done", done_m, 0);
        chk("abort_ready", if_m.load_ready, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("after_abort_idle", xv_m, 0);
        run_word(8'h0F, sm, sl);
        chk("clean_seq_msb", sm, 8'h0F);
        chk("clean_seq_lsb", sl, 8'hF0);

`ifdef SER_SKID_EN
        wait_idle();
        @(negedge clk);
        drv_valid = 1'b1;
        drv_data  = 8'hC3;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) drv_valid = 1'b0;
            if (k == 2) begin
                drv_valid = 1'b1;
                drv_data  = 8'h3C;
            end
            if (k == 3) drv_data = 8'h99;
            if (k >= 3 && k <= 7) chk("skid_stall_ready", if_m.load_ready, 0);
            if (k == 8) chk("skid_ready_again", if_m.load_ready, 1);
            if (k == 9) drv_valid = 1'b0;
            s16m[15-k] = x_m;
            s16l[15-k] = x_l;
        end
        chk("skid_seq_msb", s16m, 16'hC33C);
        chk("skid_seq_lsb", s16l, 16'hC33C);
`endif

        // Random traffic; data held stable until the model sees it accepted.
        wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!drv_valid || took) begin
                drv_valid = ($urandom_range(0, 2) != 0);
                drv_data  = W'($urandom);
            end
        end
        @(negedge clk);
        drv_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout, want completion", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream stage of the serial "101" sequence detector.
- Accepts parallel words through a valid/ready handshake and shifts them out one bit per clock on x, together with a bit-qualifier x_valid.
- A back-to-back word stream produces a gapless bit stream on x, so patterns spanning word boundaries (including overlaps) reach the detector intact.

Parameters:
- WIDTH, 8, bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block accepts a word this cycle; transfer occurs when load_valid && load_ready at a rising edge.
- x  output  1  serial bit, connects to the detector's x.
- x_valid  output  1  x carries a real bit this cycle.
- busy  output  1  a word is being shifted.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - x=0, x_valid=0, busy=0, done=0.
  - load_ready is forced 0 while rst is low.
- Outputs x, x_valid, busy and done are registered. load_ready is combinational from state and counter only, never from load_valid.
- FSM states:
  - IDLE: load_ready=1. On accept at edge N:
    - shift register <= load_data; counter <= 0; state <= SHIFT.
    - x <= first bit; x_valid <= 1; busy <= 1.
    - The first bit is therefore on x in the cycle after edge N (latency 1).
  - SHIFT: each edge advances counter and presents the next bit on x.
    - Bit k is on x in cycle N+1+k, for k = 0..WIDTH-1.
    - Bit order set by MSB_FIRST.
  - Last bit (counter==WIDTH-1):
    - done=1 for that single cycle.
    - load_ready=1 for that cycle.
  - At the edge ending the last bit:
    - If a word is accepted, load it exactly as from IDLE, with no idle cycle (gapless; x_valid stays 1, busy stays 1).
    - Otherwise return to IDLE; x<=0, x_valid<=0, busy<=0.
- load_valid during SHIFT with counter<WIDTH-1: not accepted (load_ready=0). The upstream must hold load_data stable until accepted.
- load_data changing without a handshake has no effect.
- Reset asserted mid-word: the word is aborted immediately. After release, x_valid=0 and no partial bits are replayed.
- Counter width: ceil(log2(WIDTH)); it never exceeds WIDTH-1.

Optional Feature:
- Macro: SER_SKID_EN.
- Defined: adds a one-word holding register.
  - load_ready = !hold_full, also asserted during SHIFT.
  - A word accepted during SHIFT is stored in the holding register.
  - At the last-bit edge the held word moves to the shift register gaplessly and hold_full clears the same edge.
  - A direct load in the last-bit cycle is legal only if hold is empty.
  - Reset clears hold_full.
- Not defined: no holding register; load_ready behaves exactly as in Behaviour.

Test Plan:
- Reset then load 8'hA5 with MSB_FIRST=1 -> x = 1,0,1,0,0,1,0,1 over 8 consecutive cycles starting 1 cycle after accept; x_valid high for exactly those 8; done high only on the 8th; the downstream detector reports two "101" hits.
- MSB_FIRST=0, load 8'hA5 -> x = 1,0,1,0,0,1,0,1 (0xA5 reads the same in either order); repeat with 8'h01 -> x = 1,0,0,0,0,0,0,0.
- Back-to-back 8'h05 then 8'h80 (load_valid held high, MSB_FIRST=1) -> 16 gapless bits ...0,1,0,1 | 1,0,...; x_valid never drops; load_ready high only in IDLE and in the two last-bit cycles.
- load_valid pulsed with 8'hFF at bit 3 of a word (no skid) -> ignored; current word unaltered; no extra bits appear.
- rst pulled low at bit 4 of 8'hF0 -> x=0, x_valid=0, busy=0 immediately; after release, load 8'h0F -> clean 0,0,0,0,1,1,1,1.
- SER_SKID_EN defined: second word 8'h3C accepted at bit 2 of first word 8'hC3 -> 16 gapless bits 1,1,0,0,0,0,1,1,0,0,1,1,1,1,0,0; third word stalled (load_ready=0) until the hold empties.
